// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares the single ALU between the main execute path (port 0) and the
// branch-resolution path (port 1). One operation is in flight at a time.
// The arbiter accepts a request over valid/ready and holds its opcode and
// operands on the ALU inputs. It follows the ALU's free-running four-phase
// slot and captures the registered result and flags. It then returns them to
// the owning port over a valid/ready response channel.
//
// Ports
//   soc_clk, reset             clock (rising edge), async active-high reset
//   reqN_valid/ready/op/dat1/dat2   request channel for port N (N = 0, 1)
//   rspN_valid/ready           response handshake for port N
//   rsp_out, rsp_overflow, rsp_con_met, rsp_zero, rsp_err
//                              captured result and flags, shared by both ports
//   alu_dat1, alu_dat2, alu_instr   driven from the holding registers
//   alu_accept, alu_ready      ALU slot phase indicators
//   alu_out, alu_overflow, alu_con_met, alu_zero   ALU results
//
// Optional feature: define ALU_ARB_WDOG_EN to add a 4-bit watchdog. It returns
// an error response (rsp_err = 1, result and flags = 0) when the ALU does not
// produce a result within 15 cycles of issue. Without the macro, rsp_err is
// tied to 0 and the arbiter waits for alu_ready indefinitely.

module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic              soc_clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_dat1,
  input  logic [DATA_W-1:0] req0_dat2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_dat1,
  input  logic [DATA_W-1:0] req1_dat2,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_overflow,
  output logic              rsp_con_met,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_dat1,
  output logic [DATA_W-1:0] alu_dat2,
  output logic [OP_W-1:0]   alu_instr,
  input  logic              alu_accept,
  input  logic              alu_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_overflow,
  input  logic              alu_con_met,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RESP} arbState_t;

  arbState_t         state_q;
  logic              lastServed_q;
  logic              owner_q;
  logic [OP_W-1:0]   holdOp_q;
  logic [DATA_W-1:0] holdDat1_q;
  logic [DATA_W-1:0] holdDat2_q;
  logic [DATA_W-1:0] rspOut_q;
  logic              rspOverflow_q;
  logic              rspConMet_q;
  logic              rspZero_q;
  logic              rsp0Valid_q;
  logic              rsp1Valid_q;

  logic              grantSel;
  logic              accept0;
  logic              accept1;
  logic              rspTaken;

`ifdef ALU_ARB_WDOG_EN
  logic [3:0]        wdogCnt_q;
  logic              rspErr_q;
  logic              wdogExpire;

  // The counter is cleared at accept. It holds 14 on the edge that completes
  // the 15th cycle in ISSUE+WAIT_RES.
  assign wdogExpire = (wdogCnt_q == 4'd14);
  assign rsp_err    = rspErr_q;
`else
  assign rsp_err    = 1'b0;
`endif

  // Round-robin grant. A lone valid port wins outright. On a tie, or when
  // neither port is valid, the port that was not served last is offered.
  always_comb begin
    grantSel = ~lastServed_q;
    if (req0_valid && !req1_valid) begin
      grantSel = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grantSel = 1'b1;
    end
  end

  // Ready is gated by reset so that neither port sees an accept while reset
  // is asserted, even though the state register already reads IDLE.
  assign req0_ready = ~reset & (state_q == IDLE) & ~grantSel;
  assign req1_ready = ~reset & (state_q == IDLE) &  grantSel;
  assign accept0    = req0_valid & req0_ready;
  assign accept1    = req1_valid & req1_ready;
  assign rspTaken   = owner_q ? rsp1_ready : rsp0_ready;

  assign alu_instr    = holdOp_q;
  assign alu_dat1     = holdDat1_q;
  assign alu_dat2     = holdDat2_q;
  assign rsp_out      = rspOut_q;
  assign rsp_overflow = rspOverflow_q;
  assign rsp_con_met  = rspConMet_q;
  assign rsp_zero     = rspZero_q;
  assign rsp0_valid   = rsp0Valid_q;
  assign rsp1_valid   = rsp1Valid_q;

  // Sequencer. The states are IDLE (arbitrate), ISSUE (wait for the slot's
  // accept phase), WAIT_RES (wait for that slot's result) and RESP (hold the
  // response until the owner takes it). An alu_ready seen in ISSUE belongs
  // to an older slot, so only WAIT_RES looks at it.
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      lastServed_q  <= 1'b1;
      owner_q       <= 1'b0;
      holdOp_q      <= '0;
      holdDat1_q    <= '0;
      holdDat2_q    <= '0;
      rspOut_q      <= '0;
      rspOverflow_q <= 1'b0;
      rspConMet_q   <= 1'b0;
      rspZero_q     <= 1'b0;
      rsp0Valid_q   <= 1'b0;
      rsp1Valid_q   <= 1'b0;
`ifdef ALU_ARB_WDOG_EN
      wdogCnt_q     <= '0;
      rspErr_q      <= 1'b0;
`endif
    end else begin
`ifdef ALU_ARB_WDOG_EN
      if (state_q == ISSUE || state_q == WAIT_RES) begin
        wdogCnt_q <= wdogCnt_q + 4'd1;
      end
`endif
      case (state_q)
        IDLE: begin
          if (accept0 || accept1) begin
            owner_q      <= accept1;
            lastServed_q <= accept1;
            holdOp_q     <= accept1 ? req1_op   : req0_op;
            holdDat1_q   <= accept1 ? req1_dat1 : req0_dat1;
            holdDat2_q   <= accept1 ? req1_dat2 : req0_dat2;
`ifdef ALU_ARB_WDOG_EN
            wdogCnt_q    <= '0;
`endif
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (alu_accept) begin
            state_q <= WAIT_RES;
          end
`ifdef ALU_ARB_WDOG_EN
          else if (wdogExpire) begin
            rspOut_q      <= '0;
            rspOverflow_q <= 1'b0;
            rspConMet_q   <= 1'b0;
            rspZero_q     <= 1'b0;
            rspErr_q      <= 1'b1;
            rsp0Valid_q   <= ~owner_q;
            rsp1Valid_q   <= owner_q;
            state_q       <= RESP;
          end
`endif
        end
        WAIT_RES: begin
          if (alu_ready) begin
            rspOut_q      <= alu_out;
            rspOverflow_q <= alu_overflow;
            rspConMet_q   <= alu_con_met;
            rspZero_q     <= alu_zero;
`ifdef ALU_ARB_WDOG_EN
            rspErr_q      <= 1'b0;
`endif
            rsp0Valid_q   <= ~owner_q;
            rsp1Valid_q   <= owner_q;
            state_q       <= RESP;
          end
`ifdef ALU_ARB_WDOG_EN
          else if (wdogExpire) begin
            rspOut_q      <= '0;
            rspOverflow_q <= 1'b0;
            rspConMet_q   <= 1'b0;
            rspZero_q     <= 1'b0;
            rspErr_q      <= 1'b1;
            rsp0Valid_q   <= ~owner_q;
            rsp1Valid_q   <= owner_q;
            state_q       <= RESP;
          end
`endif
        end
        RESP: begin
          if (rspTaken) begin
            rsp0Valid_q <= 1'b0;
            rsp1Valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
